// File: rtl/axi_read_slave_arbiter.sv
// Per-slave AR arbiter with round-robin grant and an order FIFO that steers
// R bursts back to the master whose AR was accepted, in acceptance order.

module axi_read_slave_arbiter_lane (
    input  logic ar_sel,
    input  logic r_sel,
    input  logic s_arready,
    input  logic s_rvalid,
    output logic m_arready,
    output logic m_rvalid
);
    assign m_arready = ar_sel & s_arready;
    assign m_rvalid  = r_sel & s_rvalid;
endmodule

module axi_read_slave_arbiter #(
    parameter int MASTERS     = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [MASTERS-1:0]            m_arvalid,
    output logic [MASTERS-1:0]            m_arready,
    input  logic [MASTERS*ADDR_WIDTH-1:0] m_araddr,
    input  logic [MASTERS*8-1:0]          m_arlen,
    input  logic [MASTERS*ID_WIDTH-1:0]   m_arid,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    output logic [ADDR_WIDTH-1:0]         s_araddr,
    output logic [7:0]                    s_arlen,
    output logic [ID_WIDTH-1:0]           s_arid,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    input  logic                          s_rlast,
    input  logic [DATA_WIDTH-1:0]         s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic [ID_WIDTH-1:0]           s_rid,
    output logic [MASTERS-1:0]            m_rvalid,
    input  logic [MASTERS-1:0]            m_rready,
    output logic [DATA_WIDTH-1:0]         m_rdata,
    output logic [1:0]                    m_rresp,
    output logic [ID_WIDTH-1:0]           m_rid,
    output logic                          m_rlast,
    output logic                          r_orphan_err
);
    localparam int GW = $clog2(MASTERS);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [GW-1:0] LAST_M   = GW'(MASTERS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] grant, rr_ptr, rr_pick;
    logic          req_found;
    int            rr_idx;

    logic [GW-1:0] fifo_mem [OUTSTANDING];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [GW-1:0] head;
    logic          fifo_empty, can_grant, ar_hs, r_pop;

    assign fifo_empty = (count == '0);
    assign can_grant  = (count < FULL_CNT);
    assign head       = fifo_mem[rd_ptr];
    assign ar_hs      = s_arvalid & s_arready;
    assign s_rready   = !fifo_empty && m_rready[head];
    assign r_pop      = s_rvalid & s_rready & s_rlast;

    // Search upward from rr_ptr; MASTERS need not be a power of two, so wrap by compare.
    always_comb begin
        rr_pick   = rr_ptr;
        req_found = 1'b0;
        rr_idx    = 0;
        for (int k = 0; k < MASTERS; k++) begin
            rr_idx = int'(rr_ptr) + k;
            if (rr_idx >= MASTERS) rr_idx = rr_idx - MASTERS;
            if (!req_found && m_arvalid[rr_idx]) begin
                req_found = 1'b1;
                rr_pick   = GW'(rr_idx);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_found && can_grant) state_nxt = GRANT;
            GRANT:   if (ar_hs)                  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_arvalid = (state == GRANT);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            if (state == IDLE && req_found && can_grant) grant <= rr_pick;
            if (ar_hs) rr_ptr <= (grant == LAST_M) ? '0 : grant + 1'b1;
        end
    end

    // Masters hold their slice stable while valid, so the mux needs no register.
    assign s_araddr = m_araddr[grant*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_arlen  = m_arlen[grant*8 +: 8];
    assign s_arid   = m_arid[grant*ID_WIDTH +: ID_WIDTH];

    always_ff @(posedge ACLK) begin
        if (ARESETn && ar_hs) fifo_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (ar_hs) wr_ptr <= wr_ptr + 1'b1;
            if (r_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({ar_hs, r_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn)                     r_orphan_err <= 1'b0;
        else if (s_rvalid && fifo_empty)  r_orphan_err <= 1'b1;
    end

    genvar i;
    generate
        for (i = 0; i < MASTERS; i++) begin : g_lane
            axi_read_slave_arbiter_lane u_lane (
                .ar_sel    (state == GRANT && grant == GW'(i)),
                .r_sel     (!fifo_empty && head == GW'(i)),
                .s_arready (s_arready),
                .s_rvalid  (s_rvalid),
                .m_arready (m_arready[i]),
                .m_rvalid  (m_rvalid[i])
            );
        end
    endgenerate

    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_rid   = s_rid;
    assign m_rlast = s_rlast;

    a_no_overflow: assert property (@(posedge ACLK) disable iff (!ARESETn) ar_hs |-> count < FULL_CNT);
    a_rvalid_1hot: assert property (@(posedge ACLK) disable iff (!ARESETn) $onehot0(m_rvalid));

endmodule

// File: tb/tb_axi_read_slave_arbiter.sv
// Scoreboard bench: expected AR grants and R routing are queued as stimulus is
// driven and compared when the DUT handshakes.

module tb_axi_read_slave_arbiter;
    localparam int M = 2, AW = 32, IW = 4, DW = 32, OST = 4;

    logic            ACLK, ARESETn;
    logic [M-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [M*AW-1:0] m_araddr;
    logic [M*8-1:0]  m_arlen;
    logic [M*IW-1:0] m_arid;
    logic            s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, m_rlast, r_orphan_err;
    logic [AW-1:0]   s_araddr;
    logic [7:0]      s_arlen;
    logic [IW-1:0]   s_arid, s_rid, m_rid;
    logic [DW-1:0]   s_rdata, m_rdata;
    logic [1:0]      s_rresp, m_rresp;

    axi_read_slave_arbiter #(.MASTERS(M), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                             .DATA_WIDTH(DW), .OUTSTANDING(OST)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arid(m_arid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arid(s_arid),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rid(m_rid), .m_rlast(m_rlast),
        .r_orphan_err(r_orphan_err)
    );

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
    } ar_exp_t;

    ar_exp_t    ar_q[$];
    logic [1:0] r_q[$];
    ar_exp_t    mon_e;
    logic [1:0] mon_rv;
    int n_checks = 0;
    int n_errors = 0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_ar(input int m, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, input bit push);
        ar_exp_t e;
        m_araddr[m*AW +: AW] = addr;
        m_arlen[m*8 +: 8]    = len;
        m_arid[m*IW +: IW]   = id;
        e.m = m; e.addr = addr; e.len = len; e.id = id;
        if (push) ar_q.push_back(e);
    endtask

    // Raise valid, hold it until the handshake edge has passed, then drop it.
    task automatic issue_ar(input int m, input logic [31:0] addr, input logic [7:0] len,
                            input logic [3:0] id);
        bit done = 1'b0;
        set_ar(m, addr, len, id, 1'b1);
        m_arvalid[m] = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (m_arready[m]) begin
                tick();
                done = 1'b1;
            end
        end
        m_arvalid[m] = 1'b0;
        if (!done) chk("ar_timeout", 64'd0, 64'd1);
    endtask

    task automatic r_burst(input int beats, input logic [1:0] exp_rv);
        for (int b = 0; b < beats; b++) begin
            r_q.push_back(exp_rv);
            s_rvalid = 1'b1;
            s_rlast  = (b == beats - 1);
            s_rdata  = $urandom;
            s_rid    = 4'(b);
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        tick();
        tick();
        ARESETn = 1'b1;
    endtask

    always @(negedge ACLK) begin
        if (ARESETn && s_arvalid && s_arready) begin
            if (ar_q.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
            else begin
                mon_e = ar_q.pop_front();
                chk("ar_addr", s_araddr, mon_e.addr);
                chk("ar_len", s_arlen, mon_e.len);
                chk("ar_id", s_arid, mon_e.id);
                chk("ar_ready", m_arready, 64'd1 << mon_e.m);
            end
        end
        if (ARESETn && s_rvalid && s_rready) begin
            if (r_q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
            else begin
                mon_rv = r_q.pop_front();
                chk("r_route", m_rvalid, mon_rv);
                chk("r_data", m_rdata, s_rdata);
                chk("r_last", m_rlast, s_rlast);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b0; m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arid = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
        s_rresp = 2'b00; s_rid = '0; m_rready = 2'b11;
        tick();
        tick();
        chk("rst_arvalid", s_arvalid, 0);
        chk("rst_arready", m_arready, 0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_rready", s_rready, 0);
        chk("rst_orphan", r_orphan_err, 0);
        ARESETn = 1'b1;

        // single master: one-cycle AR latency, 4-beat burst back to master 0
        s_arready = 1'b1;
        set_ar(0, 32'h1000_0040, 8'd3, 4'h5, 1'b1);
        m_arvalid = 2'b01;
        chk("single_arv_t0", s_arvalid, 0);
        tick();
        chk("single_arv_t1", s_arvalid, 1);
        tick();
        m_arvalid = 2'b00;
        chk("single_cnt1", dut.count, 1);
        r_burst(4, 2'b01);
        chk("single_cnt0", dut.count, 0);
        chk("single_orphan", r_orphan_err, 0);

        // contention: alternate 0,1,0,1 then fill the order FIFO
        do_reset();
        set_ar(0, 32'hA000_0000, 8'd0, 4'h1, 1'b0);
        set_ar(1, 32'hB000_0000, 8'd1, 4'h2, 1'b0);
        for (int k = 0; k < 4; k++) set_ar(k % 2, (k % 2) ? 32'hB000_0000 : 32'hA000_0000,
                                           8'(k % 2), 4'(1 + k % 2), 1'b1);
        m_arvalid = 2'b11;
        repeat (8) tick();
        chk("cont_cnt4", dut.count, 4);
        m_arvalid = 2'b01;
        set_ar(0, 32'hA000_0000, 8'd0, 4'h1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("full_hold", s_arvalid, 0);
            tick();
        end
        r_q.push_back(2'b01);
        s_rvalid = 1'b1; s_rlast = 1'b1;
        tick();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        chk("full_lat1", s_arvalid, 0);
        tick();
        chk("full_lat2", s_arvalid, 1);
        tick();
        m_arvalid = 2'b00;
        chk("full_cnt4", dut.count, 4);

        // backpressure: AR held stable for 5 cycles, ready pulses once
        do_reset();
        s_arready = 1'b0;
        set_ar(1, 32'hC0DE_0100, 8'd7, 4'h9, 1'b1);
        m_arvalid = 2'b10;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_arvalid", s_arvalid, 1);
            chk("bp_addr", s_araddr, 32'hC0DE_0100);
            chk("bp_arready", m_arready, 2'b00);
            tick();
        end
        s_arready = 1'b1;
        #1;
        chk("bp_ready_on", m_arready, 2'b10);
        tick();
        m_arvalid = 2'b00;
        chk("bp_ready_off", m_arready, 2'b00);
        chk("bp_arv_off", s_arvalid, 0);

        // ordering with a push and a pop landing on the same edge
        do_reset();
        s_arready = 1'b1;
        issue_ar(1, 32'h0000_1100, 8'd1, 4'h3);
        issue_ar(0, 32'h0000_2200, 8'd0, 4'h4);
        chk("ord_cnt2", dut.count, 2);
        r_q.push_back(2'b10);
        r_q.push_back(2'b10);
        set_ar(1, 32'h0000_3300, 8'd0, 4'h6, 1'b1);
        m_arvalid = 2'b10;
        s_rvalid = 1'b1; s_rlast = 1'b0;
        tick();
        s_rlast = 1'b1;
        chk("pp_arvalid", s_arvalid, 1);
        tick();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        m_arvalid = 2'b00;
        chk("pp_cnt", dut.count, 2);
        r_burst(1, 2'b01);
        r_burst(1, 2'b10);
        chk("ord_cnt0", dut.count, 0);

        // orphan beat, then reset while an AR is stalled in GRANT
        s_rvalid = 1'b1;
        #1;
        chk("orph_rready", s_rready, 0);
        chk("orph_rvalid", m_rvalid, 0);
        tick();
        s_rvalid = 1'b0;
        chk("orph_set", r_orphan_err, 1);
        tick();
        chk("orph_sticky", r_orphan_err, 1);
        s_arready = 1'b0;
        set_ar(0, 32'hDEAD_0000, 8'd0, 4'h0, 1'b0);
        m_arvalid = 2'b01;
        tick();
        chk("rst_pre_arv", s_arvalid, 1);
        ARESETn = 1'b0;
        tick();
        m_arvalid = 2'b00;
        chk("rst_mid_arv", s_arvalid, 0);
        chk("rst_mid_orph", r_orphan_err, 0);
        chk("rst_mid_cnt", dut.count, 0);
        ARESETn = 1'b1;
        tick();

        chk("ar_q_drained", ar_q.size(), 0);
        chk("r_q_drained", r_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_read_slave_arbiter.md
Name: axi_read_slave_arbiter

Overview:
- Per-slave read-channel arbiter for the AXI crossbar. One instance sits in front of each slave port.
- Shares the slave's AR channel among MASTERS requesters using round-robin arbitration. Requests are already qualified by the address decoder, i.e. arvalid is ANDed with dest_slave == this slave.
- Records the granted master for each accepted AR in an order FIFO. R beats are routed back to that master until RLAST.

Parameters:
- MASTERS, 2, number of requesting masters (>=2)
- ADDR_WIDTH, 32, AR address width
- ID_WIDTH, 4, AR/R ID width
- DATA_WIDTH, 32, R data width
- OUTSTANDING, 4, maximum accepted-but-incomplete bursts; order FIFO depth (power of 2)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- m_arvalid  in  MASTERS  decoder-qualified AR valid per master
- m_arready  out  MASTERS  AR ready per master
- m_araddr  in  MASTERS*ADDR_WIDTH  flattened; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_arlen  in  MASTERS*8  flattened burst lengths
- m_arid  in  MASTERS*ID_WIDTH  flattened IDs
- s_arvalid  out  1  AR valid to slave
- s_arready  in  1  AR ready from slave
- s_araddr  out  ADDR_WIDTH  muxed address
- s_arlen  out  8  muxed length
- s_arid  out  ID_WIDTH  muxed ID
- s_rvalid  in  1  R valid from slave
- s_rready  out  1  R ready to slave
- s_rlast  in  1  last beat
- s_rdata  in  DATA_WIDTH  read data
- s_rresp  in  2  response
- s_rid  in  ID_WIDTH  response ID
- m_rvalid  out  MASTERS  one-hot R valid
- m_rready  in  MASTERS  R ready per master
- m_rdata  out  DATA_WIDTH  broadcast s_rdata
- m_rresp  out  2  broadcast s_rresp
- m_rid  out  ID_WIDTH  broadcast s_rid
- m_rlast  out  1  broadcast s_rlast
- r_orphan_err  out  1  sticky: s_rvalid seen with order FIFO empty

Behaviour:
- Reset (ARESETn low at ACLK edge) forces the following:
  - state=IDLE, grant=0, rr_ptr=0, FIFO empty (count=0)
  - s_arvalid=0, m_arready=0, m_rvalid=0, s_rready=0, r_orphan_err=0
  - Reset mid-burst abandons the burst and any in-flight AR with no further handshakes.
- FSM states: IDLE, GRANT.
- IDLE:
  - Enter GRANT when any m_arvalid bit is set and count<OUTSTANDING.
  - grant = first set bit searching from rr_ptr upward, wrapping modulo MASTERS; grant is registered.
  - If count==OUTSTANDING, stay in IDLE regardless of requests.
- GRANT:
  - s_arvalid=1; s_araddr/s_arlen/s_arid driven from the granted master's slice.
  - m_arready[grant]=s_arready; all other m_arready bits are 0.
  - On s_arvalid&&s_arready: push grant into FIFO, rr_ptr=(grant+1) mod MASTERS, return to IDLE.
  - Otherwise hold all AR outputs stable. Masters obey AXI and do not drop valid.
- AR latency: request sampled in IDLE at cycle t gives s_arvalid=1 at t+1. Minimum AR spacing is 2 cycles.
- R routing, combinational from FIFO head h, when FIFO is non-empty:
  - m_rvalid = s_rvalid<<h
  - s_rready = m_rready[h]
- R routing when FIFO is empty:
  - m_rvalid=0, s_rready=0
  - s_rvalid=1 in this condition sets r_orphan_err (sticky until reset).
- Pop on s_rvalid&&s_rready&&s_rlast. Non-last beats do not pop.
- Simultaneous push and pop in one cycle: count unchanged, head advances, tail advances.
- Full: a push cannot overflow because the grant is only issued when count<OUTSTANDING and pops only reduce count.
- FIFO pointers are log2(OUTSTANDING) bits and wrap naturally. count is log2(OUTSTANDING)+1 bits.
- R data/resp/id/last are broadcast unregistered; there is no added R latency.
- MASTERS is not required to be a power of two; rr_ptr wrap uses an explicit compare.

Test Plan:
- Single master: m_arvalid=01, araddr=0x1000_0040, arlen=3, s_arready=1 -> s_arvalid high exactly 1 cycle later with addr 0x1000_0040. Then 4 R beats with rlast on the 4th -> m_rvalid=01 on each beat, count returns to 0.
- Contention: m_arvalid=11 held, s_arready=1 -> grants alternate 0,1,0,1, and rr_ptr is 1,0,1,0 after each handshake.
- Backpressure: s_arready=0 for 5 cycles in GRANT -> s_arvalid stays 1, s_araddr stable, m_arready=00. Then s_arready=1 -> m_arready[grant]=1 for exactly that cycle.
- Full: OUTSTANDING=4, issue 4 ARs with no R beats -> 5th request is held in IDLE with s_arvalid=0. One RLAST pop -> 5th AR issued 2 cycles later.
- Ordering plus simultaneous push/pop: AR from master 1 then master 0; R burst 1 completes in the same cycle as a new AR from master 1 -> count unchanged, next R beats go to m_rvalid=01 then 10.
- Orphan and reset: s_rvalid=1 with FIFO empty -> s_rready=0, r_orphan_err=1 next cycle and sticky. Assert ARESETn=0 mid-GRANT -> next edge s_arvalid=0, r_orphan_err=0, count=0.
